// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU op codes, multiply commands,
// control state encoding and the operand-magnitude helper.
package exe_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    localparam logic [4:0] CMD_MULTU = 5'b10000;
    localparam logic [4:0] CMD_MULT  = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // 0x80000000 negates to itself, which read as unsigned is the correct 2^31.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic signed_op);
        return (signed_op && v[DATA_W-1]) ? (DATA_W'(0) - v) : v;
    endfunction

endpackage

// File: rtl/exe_unit_if.sv
// Command and result handshake bundle between issue, execute and writeback.
interface exe_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_cmd;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_hi;
    logic             out_zero;
    logic             out_carry;
    logic             out_negative;
    logic             out_overflow;
    logic             busy;

    modport master (
        output in_valid, in_cmd, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_hi,
               out_zero, out_carry, out_negative, out_overflow, busy
    );

    modport slave (
        input  in_valid, in_cmd, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_hi,
               out_zero, out_carry, out_negative, out_overflow, busy
    );
endinterface

// File: rtl/alu.sv
// Combinational single-cycle ALU. Shifts move b by a[4:0]; carry is the
// unsigned carry/borrow of add/sub, overflow the signed overflow of ADD/SUB.
module alu
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           add_ovf;
    logic           sub_ovf;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        r        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (aluc)
            ALU_ADDU: begin r = sum[WIDTH-1:0];  carry = sum[WIDTH]; end
            ALU_SUBU: begin r = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
            ALU_ADD:  begin r = sum[WIDTH-1:0];  carry = sum[WIDTH];  overflow = add_ovf; end
            ALU_SUB:  begin r = diff[WIDTH-1:0]; carry = diff[WIDTH]; overflow = sub_ovf; end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_LUI:  r = {b[15:0], 16'h0000};
            ALU_SLTU: begin r = WIDTH'(diff[WIDTH]); carry = diff[WIDTH]; end
            ALU_SLT:  r = WIDTH'($signed(a) < $signed(b));
            ALU_SRA:  r = $signed(b) >>> a[4:0];
            ALU_SRL:  r = b >> a[4:0];
            ALU_SLL:  r = b << a[4:0];
            default:  r = '0;
        endcase
        zero     = (r == '0);
        negative = r[WIDTH-1];
    end

endmodule

// File: rtl/exe_unit.sv
// Execute stage: single-cycle ALU ops through alu, plus a 32-iteration
// shift-add MULT/MULTU, with registered results on a valid/ready output.
module exe_unit
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    exe_unit_if.slave  io
);

    state_t             state_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [4:0]         count_reg;
    logic               sign_reg;

    logic               out_valid_reg;
    logic [WIDTH-1:0]   out_r_reg;
    logic [WIDTH-1:0]   out_hi_reg;
    logic               zero_reg;
    logic               carry_reg;
    logic               negative_reg;
    logic               overflow_reg;
    logic               busy_reg;

    logic [WIDTH-1:0]   alu_r;
    logic               alu_zero;
    logic               alu_carry;
    logic               alu_negative;
    logic               alu_overflow;

    logic               in_ready;
    logic               accept;
    logic               mul_signed;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a        (io.in_a),
        .b        (io.in_b),
        .aluc     (io.in_cmd[3:0]),
        .r        (alu_r),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .negative (alu_negative),
        .overflow (alu_overflow)
    );

    assign in_ready   = (state_reg == IDLE) && (!out_valid_reg || io.out_ready);
    assign accept     = io.in_valid && in_ready;
    assign mul_signed = io.in_cmd[0];

    // The final iteration's sum is used directly so the result lands one edge earlier.
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign product  = sign_reg ? ((2*WIDTH)'(0) - acc_next) : acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mcand_reg     <= '0;
            acc_reg       <= '0;
            mplier_reg    <= '0;
            count_reg     <= '0;
            sign_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_r_reg     <= '0;
            out_hi_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            negative_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (out_valid_reg && io.out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                    if (accept) begin
                        if (io.in_cmd[4]) begin
                            mcand_reg  <= {{WIDTH{1'b0}}, magnitude(io.in_a, mul_signed)};
                            mplier_reg <= magnitude(io.in_b, mul_signed);
                            sign_reg   <= mul_signed && (io.in_a[WIDTH-1] ^ io.in_b[WIDTH-1]);
                            acc_reg    <= '0;
                            count_reg  <= '0;
                            busy_reg   <= 1'b1;
                            state_reg  <= MUL;
                        end else begin
                            out_valid_reg <= 1'b1;
                            out_r_reg     <= alu_r;
                            out_hi_reg    <= '0;
                            zero_reg      <= alu_zero;
                            carry_reg     <= alu_carry;
                            negative_reg  <= alu_negative;
                            overflow_reg  <= alu_overflow;
                        end
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        out_valid_reg <= 1'b1;
                        out_r_reg     <= product[WIDTH-1:0];
                        out_hi_reg    <= product[2*WIDTH-1:WIDTH];
                        zero_reg      <= (product == '0);
                        carry_reg     <= 1'b0;
                        negative_reg  <= product[2*WIDTH-1];
                        overflow_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (io.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io.in_ready     = in_ready;
    assign io.out_valid    = out_valid_reg;
    assign io.out_r        = out_r_reg;
    assign io.out_hi       = out_hi_reg;
    assign io.out_zero     = zero_reg;
    assign io.out_carry    = carry_reg;
    assign io.out_negative = negative_reg;
    assign io.out_overflow = overflow_reg;
    assign io.busy         = busy_reg;

endmodule

// File: tb/tb_exe_unit.sv
// Self-checking bench for exe_unit: directed vector table, hand-written
// handshake/reset sequences and randomized commands against a reference model.
module tb_exe_unit;
    import exe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exe_unit_if #(.WIDTH(32)) io ();

    exe_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [31:0] hi;
        logic [3:0]  fl;   // {zero, carry, negative, overflow}
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {io.out_zero, io.out_carry, io.out_negative, io.out_overflow};
    endfunction

    // Reference behaviour from the arithmetic definitions, using wide integers.
    function automatic void model(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] hi, output logic [3:0] fl);
        logic [63:0] p;
        logic [63:0] u;
        longint      s;
        logic        c;
        logic        v;
        r = '0; hi = '0; c = 1'b0; v = 1'b0;
        if (cmd[4]) begin
            if (cmd[0]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else        p = {32'h0, a} * {32'h0, b};
            r  = p[31:0];
            hi = p[63:32];
            fl = {p == 64'h0, 1'b0, p[63], 1'b0};
        end else begin
            case (cmd[3:0])
                ALU_ADDU, ALU_ADD: begin
                    u = {32'h0, a} + {32'h0, b};
                    r = u[31:0];
                    c = u > 64'hFFFF_FFFF;
                    s = longint'($signed(a)) + longint'($signed(b));
                    v = (cmd[3:0] == ALU_ADD) && (s > 64'sd2147483647 || s < -64'sd2147483648);
                end
                ALU_SUBU, ALU_SUB: begin
                    r = a - b;
                    c = a < b;
                    s = longint'($signed(a)) - longint'($signed(b));
                    v = (cmd[3:0] == ALU_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
                end
                ALU_AND:  r = a & b;
                ALU_OR:   r = a | b;
                ALU_XOR:  r = a ^ b;
                ALU_NOR:  r = ~(a | b);
                ALU_LUI:  r = b * 32'd65536;
                ALU_SLTU: begin r = (a < b) ? 32'd1 : 32'd0; c = a < b; end
                ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                ALU_SRA:  r = 32'(longint'($signed(b)) >>> a[4:0]);
                ALU_SRL:  r = b / (32'd1 << a[4:0]);
                ALU_SLL:  r = b * (32'd1 << a[4:0]);
                default:  r = '0;
            endcase
            fl = {r == 32'h0, c, r[31], v};
        end
    endfunction

    // Issue one command, check latency/busy/result, hold it for `stall` cycles, then consume.
    task automatic do_txn(input string tag, input logic [4:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic [31:0] ehi,
                          input logic [3:0] efl, input int stall);
        int g;
        int lat;
        int bcnt;
        io.out_ready = 1'b0;
        io.in_cmd    = cmd;
        io.in_a      = a;
        io.in_b      = b;
        io.in_valid  = 1'b1;
        g = 0;
        while (!io.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk({tag, " in_ready"}, 64'(io.in_ready), 64'd1);
        @(negedge clk);
        io.in_valid = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!io.out_valid && lat < 40) begin
            bcnt += int'(io.busy);
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), cmd[4] ? 64'd33 : 64'd1);
        chk({tag, " busy_cycles"}, 64'(bcnt), cmd[4] ? 64'd32 : 64'd0);
        chk({tag, " out_r"}, 64'(io.out_r), 64'(er));
        chk({tag, " out_hi"}, 64'(io.out_hi), 64'(ehi));
        chk({tag, " flags"}, 64'(flags_now()), 64'(efl));
        $display("txn %s cmd=%b a=%h b=%h -> hi=%h r=%h zcnv=%b lat=%0d",
                 tag, cmd, a, b, io.out_hi, io.out_r, flags_now(), lat);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, " hold out_r"}, 64'(io.out_r), 64'(er));
            chk({tag, " hold out_hi"}, 64'(io.out_hi), 64'(ehi));
            chk({tag, " hold in_ready"}, 64'(io.in_ready), 64'd0);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, " consumed"}, 64'(io.out_valid), 64'd0);
        io.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mr, mhi, ra, rb;
        logic [3:0]  mfl;
        logic [4:0]  rcmd;
        logic [3:0]  codes[14];

        vecs[0]  = '{5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'b0011};
        vecs[1]  = '{5'b00100, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 32'h0, 4'b1000};
        vecs[2]  = '{5'b00101, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0, 4'b0010};
        vecs[3]  = '{5'b00001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 4'b0110};
        vecs[4]  = '{5'b01011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 4'b0000};
        vecs[5]  = '{5'b01010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b1000};
        vecs[6]  = '{5'b01000, 32'h12345678, 32'h0000ABCD, 32'hABCD0000, 32'h0, 4'b0010};
        vecs[7]  = '{5'b01100, 32'h00000004, 32'h80000000, 32'hF8000000, 32'h0, 4'b0010};
        vecs[8]  = '{5'b01101, 32'h00000004, 32'h80000000, 32'h08000000, 32'h0, 4'b0000};
        vecs[9]  = '{5'b01110, 32'h0000001F, 32'h00000003, 32'h80000000, 32'h0, 4'b0010};
        vecs[10] = '{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b1100};
        vecs[11] = '{5'b00011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'b0001};
        vecs[12] = '{5'b00111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 4'b0010};
        vecs[13] = '{5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 4'b0000};
        vecs[14] = '{CMD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b0010};
        vecs[15] = '{CMD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 4'b0010};
        vecs[16] = '{CMD_MULT,  32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 4'b1000};
        vecs[17] = '{CMD_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 4'b0000};
        vecs[18] = '{5'b11110,  32'h00000002, 32'h00000003, 32'h00000006, 32'h00000000, 4'b0000};
        vecs[19] = '{5'b11111,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b0010};
        vecs[20] = '{5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b1100};

        codes = '{ALU_ADDU, ALU_SUBU, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                  ALU_NOR, ALU_LUI, ALU_SLTU, ALU_SLT, ALU_SRA, ALU_SRL, ALU_SLL};

        io.in_valid = 1'b0; io.in_cmd = '0; io.in_a = '0; io.in_b = '0; io.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", 64'(io.out_valid), 64'd0);
        chk("reset out_r", 64'(io.out_r), 64'd0);
        chk("reset out_hi", 64'(io.out_hi), 64'd0);
        chk("reset flags", 64'(flags_now()), 64'd0);
        chk("reset busy", 64'(io.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 64'(io.in_ready), 64'd1);

        // Directed vector table
        for (int i = 0; i < 21; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].a, vecs[i].b,
                   vecs[i].r, vecs[i].hi, vecs[i].fl, 0);
        end

        // Back-to-back AND then OR with out_ready held high
        io.out_ready = 1'b1;
        io.in_valid  = 1'b1;
        io.in_cmd    = {1'b0, ALU_AND};
        io.in_a      = 32'h55555555;
        io.in_b      = 32'hAAAAAAAA;
        chk("b2b in_ready0", 64'(io.in_ready), 64'd1);
        @(negedge clk);
        chk("b2b and valid", 64'(io.out_valid), 64'd1);
        chk("b2b and r", 64'(io.out_r), 64'h0);
        chk("b2b and zero", 64'(io.out_zero), 64'd1);
        chk("b2b in_ready1", 64'(io.in_ready), 64'd1);
        io.in_cmd = {1'b0, ALU_OR};
        @(negedge clk);
        chk("b2b or valid", 64'(io.out_valid), 64'd1);
        chk("b2b or r", 64'(io.out_r), 64'hFFFFFFFF);
        chk("b2b or zero", 64'(io.out_zero), 64'd0);
        chk("b2b in_ready2", 64'(io.in_ready), 64'd1);
        $display("txn b2b AND/OR -> r=%h", io.out_r);
        io.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b drained", 64'(io.out_valid), 64'd0);

        // Backpressure: SUB held 5 cycles while an SLT waits, then both handshakes in one cycle
        io.out_ready = 1'b0;
        io.in_valid  = 1'b1;
        io.in_cmd    = {1'b0, ALU_SUB};
        io.in_a      = 32'd10;
        io.in_b      = 32'd3;
        @(negedge clk);
        io.in_cmd = {1'b0, ALU_SLT};
        io.in_a   = 32'hFFFFFFFF;
        io.in_b   = 32'h00000001;
        for (int i = 0; i < 5; i++) begin
            chk("bp sub valid", 64'(io.out_valid), 64'd1);
            chk("bp sub r", 64'(io.out_r), 64'd7);
            chk("bp sub flags", 64'(flags_now()), 64'd0);
            chk("bp in_ready", 64'(io.in_ready), 64'd0);
            @(negedge clk);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("bp slt valid", 64'(io.out_valid), 64'd1);
        chk("bp slt r", 64'(io.out_r), 64'd1);
        $display("txn backpressure SUB->SLT r=%h", io.out_r);
        io.in_valid = 1'b0;
        @(negedge clk);
        chk("bp drained", 64'(io.out_valid), 64'd0);
        io.out_ready = 1'b0;

        // Reset in the middle of a MULTU
        io.in_valid = 1'b1;
        io.in_cmd   = CMD_MULTU;
        io.in_a     = 32'h12345678;
        io.in_b     = 32'h9ABCDEF0;
        @(negedge clk);
        io.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort busy before", 64'(io.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(io.out_valid), 64'd0);
        chk("abort busy", 64'(io.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort in_ready", 64'(io.in_ready), 64'd1);
        do_txn("after-abort addu", {1'b0, ALU_ADDU}, 32'd1, 32'd1, 32'd2, 32'd0, 4'b0000, 0);

        // Randomized commands with random output stalls
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) rcmd = {1'b1, 4'($urandom_range(0, 15))};
            else                           rcmd = {1'b0, codes[$urandom_range(0, 13)]};
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                2:       ra = 32'($urandom_range(0, 40));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h7FFFFFFF;
                1:       rb = 32'h80000000;
                2:       rb = 32'($urandom_range(0, 40));
                default: rb = $urandom;
            endcase
            model(rcmd, ra, rb, mr, mhi, mfl);
            do_txn($sformatf("rnd%0d", i), rcmd, ra, rb, mr, mhi, mfl, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
